// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side SD CMD line: frame receiver with CRC7 check and
// response serialiser with a programmable NCR gap.
module sd_card_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        icmd_sd,
    output logic        ocmd_sd,
    output logic        ocmd_oe,
    output logic        ocmd_valid,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ocrc_err,
    input  logic        iresp_start,
    input  logic [5:0]  iresp_index,
    input  logic [31:0] iresp_arg,
    input  logic        iresp_nocrc,
    output logic        oresp_busy,
    output logic        oresp_done
);

    typedef enum logic [2:0] {IDLE, RX, CHECK, NCR_WAIT, TX} state_t;

    localparam logic [6:0] NCR_LAST = 7'(NCR - 1);

    state_t      state;
    state_t      state_next;
    logic [6:0]  cnt;
    logic [6:0]  crc;
    logic [45:0] rx_shreg;
    logic [46:0] rx_bits;
    logic        frame_ok;
    logic [39:0] tx_shreg;
    logic        tx_nocrc;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Frame bits 46..0 as seen on the last RX cycle; the start bit is implied.
    assign rx_bits  = {rx_shreg, icmd_sd};
    assign frame_ok = rx_bits[46] && (rx_bits[7:1] == crc) && rx_bits[0];

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!icmd_sd) begin
                    state_next = RX;
                end else if (iresp_start) begin
                    state_next = NCR_WAIT;
                end
            end
            RX:       if (cnt == 7'd47) state_next = CHECK;
            CHECK:    state_next = IDLE;
            NCR_WAIT: if (cnt == NCR_LAST) state_next = TX;
            TX:       if (cnt == 7'd47) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        ocmd_sd    = 1'b1;
        ocmd_oe    = 1'b0;
        oresp_busy = (state != IDLE);
        if (state == TX) begin
            ocmd_oe = 1'b1;
            if (cnt < 7'd40) begin
                ocmd_sd = tx_shreg[39];
            end else if (cnt < 7'd47) begin
                ocmd_sd = tx_nocrc | crc[6];
            end
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            cnt        <= '0;
            crc        <= '0;
            rx_shreg   <= '0;
            tx_shreg   <= '0;
            tx_nocrc   <= 1'b0;
            ocmd_valid <= 1'b0;
            ocrc_err   <= 1'b0;
            ocmd_index <= '0;
            ocmd_arg   <= '0;
            oresp_done <= 1'b0;
        end else begin
            ocmd_valid <= 1'b0;
            ocrc_err   <= 1'b0;
            oresp_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The start bit is a zero, so it leaves the CRC at its initial value.
                    if (!icmd_sd) begin
                        cnt      <= 7'd1;
                        crc      <= '0;
                        rx_shreg <= '0;
                    end else if (iresp_start) begin
                        cnt      <= '0;
                        crc      <= '0;
                        tx_shreg <= {2'b00, iresp_index, iresp_arg};
                        tx_nocrc <= iresp_nocrc;
                    end
                end
                RX: begin
                    rx_shreg <= rx_bits[45:0];
                    cnt      <= cnt + 7'd1;
                    if (cnt < 7'd40) begin
                        crc <= crc7_step(crc, icmd_sd);
                    end
                    if (cnt == 7'd47) begin
                        ocmd_valid <= frame_ok;
                        ocrc_err   <= !frame_ok;
                        if (frame_ok) begin
                            ocmd_index <= rx_bits[45:40];
                            ocmd_arg   <= rx_bits[39:8];
                        end
                    end
                end
                NCR_WAIT: begin
                    cnt <= (cnt == NCR_LAST) ? 7'd0 : cnt + 7'd1;
                end
                TX: begin
                    cnt <= cnt + 7'd1;
                    if (cnt < 7'd40) begin
                        crc      <= crc7_step(crc, tx_shreg[39]);
                        tx_shreg <= {tx_shreg[38:0], 1'b0};
                    end else begin
                        crc <= {crc[5:0], 1'b0};
                    end
                    if (cnt == 7'd47) begin
                        oresp_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
